color_mixer_arbiter: RTL and testbench
======================================

Name: color_mixer_arbiter

Overview:
- Shares one 2-stage ColorMixer between two independent requesters, e.g. the texture-environment stage (port 0) and the framebuffer-blend stage (port 1).
- Each requester uses a valid/ready stream carrying four colour operands plus a user tag.
- The block does round-robin arbitration, tracks requester ID and tag alongside the mixer pipeline, and routes each result to the matching output stream.
- Backpressure is applied to the whole mixer through its ce input.

Parameters:
- SUB_PIXEL_WIDTH, 8, width of one colour channel. A pixel is 4 channels, so PIXEL_WIDTH = 4*SUB_PIXEL_WIDTH.
- USER_WIDTH, 16, width of the opaque tag carried with each request (fragment index, etc.).

Ports:
- aclk  in  1  sole clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- s0_valid  in  1  requester 0 operand valid.
- s0_ready  out  1  requester 0 operand accepted this cycle.
- s0_colorA, s0_colorB, s0_colorC, s0_colorD  in  PIXEL_WIDTH each  operands; the mixer computes A*B + C*D with saturation.
- s0_user  in  USER_WIDTH  tag for requester 0.
- s1_valid, s1_ready, s1_colorA..D, s1_user  same as above for requester 1.
- m0_valid  out  1  result for requester 0 valid.
- m0_ready  in  1  consumer 0 accepts the result.
- m0_color  out  PIXEL_WIDTH  mixed result.
- m0_user  out  USER_WIDTH  echoed tag.
- m1_valid, m1_ready, m1_color, m1_user  same as above for requester 1.

Behaviour:
- Clock/reset: one clock, aclk; reset is synchronous and active-high. The mixer's resetn is driven by ~reset.
- Pipeline tracking:
  - Shadow registers v1/id1/user1 and v2/id2/user2 align with mixer stages 1 and 2.
  - All of them advance only when ce = 1.
- Global enable: ce = !v2 || (id2 ? m1_ready : m0_ready). This is combinational from m*_ready to s*_ready and is accepted as such.
- Output routing:
  - m0_valid = v2 && !id2; m1_valid = v2 && id2.
  - mN_color = mixer mixedColor; mN_user = user2.
  - mN_color and mN_user are don't-care when mN_valid = 0.
- Arbitration:
  - Round-robin pointer rr (1 bit) names the preferred port.
  - grant = rr if s[rr]_valid, else the other port if its valid is set, else none.
  - sN_ready = ce && grant==N, combinational.
  - sN_ready must not depend on sN_valid other than through the grant, and must never be asserted for both ports in one cycle.
- Acceptance:
  - A transfer occurs when sN_valid && sN_ready.
  - The operand mux feeds the granted port's colours into the mixer that same cycle. Inputs of the non-granted port are ignored.
  - On a transfer: v1<=1, id1<=N, user1<=sN_user, and rr<=~N.
  - If ce and no transfer, v1<=0 (a bubble enters).
- Stage advance: when ce, v2<=v1, id2<=id1, user2<=user1.
- Latency: transfer in cycle T produces mN_valid in cycle T+2 when ce stays high. Throughput is 1 result per cycle with both sinks ready.
- Stall:
  - With ce=0 the mixer, v1/v2 and rr all hold.
  - Both s*_ready are 0, and the held result stays stable on mN_color/mN_user.
  - Head-of-line blocking is intended: a stalled consumer 0 also stalls results queued for consumer 1.
- Idle: with no valid inputs, bubbles flush the pipeline; m*_valid drops 2 cycles after the last transfer.
- Reset values (registered, applied in the same clock edge):
  - v1=0, v2=0, rr=0, id1=id2=0.
  - Hence m0_valid=m1_valid=0.
  - s*_ready evaluates to 0 only if no valid is present; ce=1 after reset.
- Reset mid-operation: in-flight results are discarded without emission. The first grant after reset goes to port 0 when both are valid.
- Arithmetic: per channel, result = saturate((A*B + C*D + (2^W-1)) >> W). This is fully done in the mixer; the arbiter adds no arithmetic.

Decomposition:
- A shared package/header (alongside PixelUtil.vh) holds:
  - NUMBER_OF_SUB_PIXEL=4.
  - the PIXEL_WIDTH derivation.
  - requester ID constants REQ_TEX=0 and REQ_BLEND=1.
- One sub-module: the existing ColorMixer, instantiated once and wired to aclk, ~reset, ce, the operand mux and mixedColor.
- Arbitration plus shadow pipeline stays inline (about 150 lines).

Test Plan:
- Single request: s0 A=0xFFFFFFFF, B=0x80808080, C=D=0, user=0x1234 at cycle T, m0_ready=1 → m0_valid at T+2 with m0_color=0x80808080 and m0_user=0x1234; m1_valid stays 0.
- Saturation: s1 A=B=C=D=0xFFFFFFFF → m1_color=0xFFFFFFFF. Separately, A=B=C=D=0 → 0x00000000.
- Round-robin: s0 and s1 valid every cycle, all ready → accepts alternate 0,1,0,1 starting with port 0 after reset; outputs alternate m0,m1 with users in order; 1 result per cycle.
- Backpressure: result for port 0 at head with m0_ready=0 for 3 cycles → ce=0, s0_ready=s1_ready=0, m0_color/m0_user stable, queued m1 result held. On m0_ready=1 the flow resumes with no loss or duplication.
- Single contender: only s1 valid for 4 cycles while rr=0 → s1 granted every cycle. Then s0 valid joins → next grant goes to port 0.
- Reset mid-flight: 2 requests in flight, assert reset for 1 cycle → m*_valid=0 afterwards with no stale results emitted; the next simultaneous request is granted to port 0.

Source files
------------

// File: rtl/color_mixer_arbiter_pkg.sv
// Shared constants for the colour-mixer arbiter: pixel geometry and requester IDs.
package color_mixer_arbiter_pkg;

    localparam int NUMBER_OF_SUB_PIXEL = 4;

    localparam logic REQ_TEX   = 1'b0;
    localparam logic REQ_BLEND = 1'b1;

    function automatic int pixel_width(input int sub_pixel_width);
        return NUMBER_OF_SUB_PIXEL * sub_pixel_width;
    endfunction

endpackage

// File: rtl/color_mixer_arbiter_mixer.sv
// Two-stage colour mixer: per channel saturate((A*B + C*D + 2^W-1) >> W).
// Stage 1 registers the product sum, stage 2 the rounded, saturated channel.
module color_mixer_arbiter_mixer
    import color_mixer_arbiter_pkg::*;
#(
    parameter int SUB_PIXEL_WIDTH = 8,
    localparam int PIXEL_WIDTH = NUMBER_OF_SUB_PIXEL * SUB_PIXEL_WIDTH
) (
    input  logic                   aclk,
    input  logic                   resetn,
    input  logic                   ce,
    input  logic [PIXEL_WIDTH-1:0] color_a,
    input  logic [PIXEL_WIDTH-1:0] color_b,
    input  logic [PIXEL_WIDTH-1:0] color_c,
    input  logic [PIXEL_WIDTH-1:0] color_d,
    output logic [PIXEL_WIDTH-1:0] mixed_color
);

    localparam int W = SUB_PIXEL_WIDTH;

    for (genvar ch = 0; ch < NUMBER_OF_SUB_PIXEL; ch++) begin : g_ch
        logic [W-1:0]   ca, cb, cc, cd;
        logic [2*W-1:0] prod_ab, prod_cd;
        logic [2*W:0]   sum_d, sum_q, rounded;
        logic [W:0]     shifted;
        logic [W-1:0]   sat, res_q;

        assign ca = color_a[ch*W +: W];
        assign cb = color_b[ch*W +: W];
        assign cc = color_c[ch*W +: W];
        assign cd = color_d[ch*W +: W];

        assign prod_ab = {{W{1'b0}}, ca} * {{W{1'b0}}, cb};
        assign prod_cd = {{W{1'b0}}, cc} * {{W{1'b0}}, cd};
        assign sum_d   = {1'b0, prod_ab} + {1'b0, prod_cd};

        // Worst case 2*(2^W-1)^2 + 2^W-1 still fits in 2W+1 bits.
        assign rounded = sum_q + {{(W+1){1'b0}}, {W{1'b1}}};
        assign shifted = rounded[2*W:W];
        assign sat     = shifted[W] ? {W{1'b1}} : shifted[W-1:0];

        always_ff @(posedge aclk) begin
            if (!resetn) begin
                sum_q <= '0;
                res_q <= '0;
            end else if (ce) begin
                sum_q <= sum_d;
                res_q <= sat;
            end
        end

        assign mixed_color[ch*W +: W] = res_q;
    end

endmodule

// File: rtl/color_mixer_arbiter.sv
// Round-robin share of one two-stage colour mixer between two requesters,
// with requester ID and tag carried alongside the mixer pipeline.
module color_mixer_arbiter
    import color_mixer_arbiter_pkg::*;
#(
    parameter int SUB_PIXEL_WIDTH = 8,
    parameter int USER_WIDTH      = 16,
    localparam int PIXEL_WIDTH = NUMBER_OF_SUB_PIXEL * SUB_PIXEL_WIDTH
) (
    input  logic                   aclk,
    input  logic                   reset,

    input  logic                   s0_valid,
    output logic                   s0_ready,
    input  logic [PIXEL_WIDTH-1:0] s0_colorA,
    input  logic [PIXEL_WIDTH-1:0] s0_colorB,
    input  logic [PIXEL_WIDTH-1:0] s0_colorC,
    input  logic [PIXEL_WIDTH-1:0] s0_colorD,
    input  logic [USER_WIDTH-1:0]  s0_user,

    input  logic                   s1_valid,
    output logic                   s1_ready,
    input  logic [PIXEL_WIDTH-1:0] s1_colorA,
    input  logic [PIXEL_WIDTH-1:0] s1_colorB,
    input  logic [PIXEL_WIDTH-1:0] s1_colorC,
    input  logic [PIXEL_WIDTH-1:0] s1_colorD,
    input  logic [USER_WIDTH-1:0]  s1_user,

    output logic                   m0_valid,
    input  logic                   m0_ready,
    output logic [PIXEL_WIDTH-1:0] m0_color,
    output logic [USER_WIDTH-1:0]  m0_user,

    output logic                   m1_valid,
    input  logic                   m1_ready,
    output logic [PIXEL_WIDTH-1:0] m1_color,
    output logic [USER_WIDTH-1:0]  m1_user
);

    logic                   ce;
    logic                   rr;
    logic                   grant_valid;
    logic                   grant_id;
    logic                   transfer;

    logic                   v1, v2;
    logic                   id1, id2;
    logic [USER_WIDTH-1:0]  user1, user2;

    logic [PIXEL_WIDTH-1:0] mix_a, mix_b, mix_c, mix_d;
    logic [PIXEL_WIDTH-1:0] mixed_color;
    logic [USER_WIDTH-1:0]  grant_user;

    // Whole pipeline stalls when the result at the head is not taken.
    assign ce = !v2 || (id2 ? m1_ready : m0_ready);

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = rr;
        if (rr ? s1_valid : s0_valid) begin
            grant_valid = 1'b1;
            grant_id    = rr;
        end else if (rr ? s0_valid : s1_valid) begin
            grant_valid = 1'b1;
            grant_id    = ~rr;
        end
    end

    assign s0_ready = ce && grant_valid && (grant_id == REQ_TEX);
    assign s1_ready = ce && grant_valid && (grant_id == REQ_BLEND);
    assign transfer = ce && grant_valid;

    always_comb begin
        mix_a      = s0_colorA;
        mix_b      = s0_colorB;
        mix_c      = s0_colorC;
        mix_d      = s0_colorD;
        grant_user = s0_user;
        if (grant_id == REQ_BLEND) begin
            mix_a      = s1_colorA;
            mix_b      = s1_colorB;
            mix_c      = s1_colorC;
            mix_d      = s1_colorD;
            grant_user = s1_user;
        end
    end

    // Tags are don't-care while their valid bit is low, so only control state resets.
    always_ff @(posedge aclk) begin
        if (reset) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            id1 <= 1'b0;
            id2 <= 1'b0;
            rr  <= 1'b0;
        end else if (ce) begin
            v1  <= transfer;
            v2  <= v1;
            id2 <= id1;
            if (transfer) begin
                id1 <= grant_id;
                rr  <= ~grant_id;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (ce) begin
            if (transfer) user1 <= grant_user;
            user2 <= user1;
        end
    end

    color_mixer_arbiter_mixer #(
        .SUB_PIXEL_WIDTH (SUB_PIXEL_WIDTH)
    ) u_mixer (
        .aclk        (aclk),
        .resetn      (~reset),
        .ce          (ce),
        .color_a     (mix_a),
        .color_b     (mix_b),
        .color_c     (mix_c),
        .color_d     (mix_d),
        .mixed_color (mixed_color)
    );

    assign m0_valid = v2 && (id2 == REQ_TEX);
    assign m1_valid = v2 && (id2 == REQ_BLEND);
    assign m0_color = mixed_color;
    assign m1_color = mixed_color;
    assign m0_user  = user2;
    assign m1_user  = user2;

endmodule

// File: tb/tb_color_mixer_arbiter.sv
// Directed bench for color_mixer_arbiter: reset, mixing, round-robin, stall, reset mid-flight.
module tb_color_mixer_arbiter;

    logic        aclk = 1'b0;
    logic        reset;
    logic        s0_valid, s0_ready, s1_valid, s1_ready;
    logic [31:0] s0_colorA, s0_colorB, s0_colorC, s0_colorD;
    logic [31:0] s1_colorA, s1_colorB, s1_colorC, s1_colorD;
    logic [15:0] s0_user, s1_user;
    logic        m0_valid, m0_ready, m1_valid, m1_ready;
    logic [31:0] m0_color, m1_color;
    logic [15:0] m0_user, m1_user;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 aclk = ~aclk;

    color_mixer_arbiter dut (
        .aclk      (aclk),      .reset     (reset),
        .s0_valid  (s0_valid),  .s0_ready  (s0_ready),
        .s0_colorA (s0_colorA), .s0_colorB (s0_colorB),
        .s0_colorC (s0_colorC), .s0_colorD (s0_colorD),
        .s0_user   (s0_user),
        .s1_valid  (s1_valid),  .s1_ready  (s1_ready),
        .s1_colorA (s1_colorA), .s1_colorB (s1_colorB),
        .s1_colorC (s1_colorC), .s1_colorD (s1_colorD),
        .s1_user   (s1_user),
        .m0_valid  (m0_valid),  .m0_ready  (m0_ready),
        .m0_color  (m0_color),  .m0_user   (m0_user),
        .m1_valid  (m1_valid),  .m1_ready  (m1_ready),
        .m1_color  (m1_color),  .m1_user   (m1_user)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic mid();
        @(negedge aclk);
    endtask

    task automatic set0(input logic v, input logic [31:0] a, b, c, d, input logic [15:0] u);
        s0_valid = v; s0_colorA = a; s0_colorB = b; s0_colorC = c; s0_colorD = d; s0_user = u;
    endtask

    task automatic set1(input logic v, input logic [31:0] a, b, c, d, input logic [15:0] u);
        s1_valid = v; s1_colorA = a; s1_colorB = b; s1_colorC = c; s1_colorD = d; s1_user = u;
    endtask

    task automatic idle();
        set0(1'b0, '0, '0, '0, '0, '0);
        set1(1'b0, '0, '0, '0, '0, '0);
    endtask

    initial begin
        reset = 1'b1; m0_ready = 1'b1; m1_ready = 1'b1;
        idle();
        tick(); tick();
        mid();
        chk("rst_m0_valid", 64'(m0_valid), 64'(0));
        chk("rst_m1_valid", 64'(m1_valid), 64'(0));
        chk("rst_s0_ready", 64'(s0_ready), 64'(0));
        chk("rst_s1_ready", 64'(s1_ready), 64'(0));
        reset = 1'b0;
        tick();

        // single request on port 0: 0xFF*0x80 rounds to 0x80
        set0(1'b1, 32'hFFFFFFFF, 32'h80808080, 32'h0, 32'h0, 16'h1234);
        mid();
        chk("single_s0_ready", 64'(s0_ready), 64'(1));
        chk("single_s1_ready", 64'(s1_ready), 64'(0));
        tick();
        idle();
        mid();
        chk("single_t1_m0_valid", 64'(m0_valid), 64'(0));
        tick();
        mid();
        chk("single_m0_valid", 64'(m0_valid), 64'(1));
        chk("single_m0_color", 64'(m0_color), 64'(32'h80808080));
        chk("single_m0_user",  64'(m0_user),  64'(16'h1234));
        chk("single_m1_valid", 64'(m1_valid), 64'(0));
        tick();
        mid();
        chk("single_t3_m0_valid", 64'(m0_valid), 64'(0));
        tick();

        // saturation high and all-zero floor on port 1
        set1(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'hBEEF);
        mid();
        chk("sat_s1_ready", 64'(s1_ready), 64'(1));
        tick();
        set1(1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 16'h0001);
        tick();
        idle();
        mid();
        chk("sat_m1_valid", 64'(m1_valid), 64'(1));
        chk("sat_m1_color", 64'(m1_color), 64'(32'hFFFFFFFF));
        chk("sat_m1_user",  64'(m1_user),  64'(16'hBEEF));
        tick();
        mid();
        chk("zero_m1_valid", 64'(m1_valid), 64'(1));
        chk("zero_m1_color", 64'(m1_color), 64'(32'h0));
        chk("zero_m1_user",  64'(m1_user),  64'(16'h0001));
        tick(); tick();

        // round-robin from reset: grants alternate 0,1,0,1...
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                set0(1'b1, 32'hFFFFFFFF, 32'h10203040, 32'h0, 32'h0, 16'hA000 + 16'(i/2));
                set1(1'b1, 32'hFFFFFFFF, 32'h05060708, 32'h0, 32'h0, 16'hB000 + 16'(i/2));
            end else idle();
            mid();
            if (i < 6) begin
                chk("rr_s0_ready", 64'(s0_ready), 64'(i % 2 == 0));
                chk("rr_s1_ready", 64'(s1_ready), 64'(i % 2 == 1));
            end
            if (i >= 2) begin
                chk("rr_m0_valid", 64'(m0_valid), 64'(i % 2 == 0));
                chk("rr_m1_valid", 64'(m1_valid), 64'(i % 2 == 1));
                if (i % 2 == 0) begin
                    chk("rr_m0_user",  64'(m0_user),  64'(16'hA000 + 16'((i-2)/2)));
                    chk("rr_m0_color", 64'(m0_color), 64'(32'h10203040));
                end else begin
                    chk("rr_m1_user",  64'(m1_user),  64'(16'hB000 + 16'((i-2)/2)));
                    chk("rr_m1_color", 64'(m1_color), 64'(32'h05060708));
                end
            end
            tick();
        end
        tick();

        // backpressure: port-0 result stuck at head, port-1 result queued behind it
        set0(1'b1, 32'hFFFFFFFF, 32'h11223344, 32'h0, 32'h0, 16'h0C01);
        set1(1'b1, 32'hFFFFFFFF, 32'h55667788, 32'h0, 32'h0, 16'h0D01);
        mid();
        chk("bp_c0_s0_ready", 64'(s0_ready), 64'(1));
        tick();
        mid();
        chk("bp_c1_s1_ready", 64'(s1_ready), 64'(1));
        chk("bp_c1_s0_ready", 64'(s0_ready), 64'(0));
        tick();
        set0(1'b1, 32'hFFFFFFFF, 32'h11223344, 32'h0, 32'h0, 16'h0C02);
        s1_valid = 1'b0;
        m0_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("bp_stall_m0_valid", 64'(m0_valid), 64'(1));
            chk("bp_stall_m0_color", 64'(m0_color), 64'(32'h11223344));
            chk("bp_stall_m0_user",  64'(m0_user),  64'(16'h0C01));
            chk("bp_stall_m1_valid", 64'(m1_valid), 64'(0));
            chk("bp_stall_s0_ready", 64'(s0_ready), 64'(0));
            chk("bp_stall_s1_ready", 64'(s1_ready), 64'(0));
            tick();
        end
        m0_ready = 1'b1;
        mid();
        chk("bp_resume_m0_user",  64'(m0_user),  64'(16'h0C01));
        chk("bp_resume_s0_ready", 64'(s0_ready), 64'(1));
        tick();
        idle();
        mid();
        chk("bp_q_m1_valid", 64'(m1_valid), 64'(1));
        chk("bp_q_m1_user",  64'(m1_user),  64'(16'h0D01));
        chk("bp_q_m1_color", 64'(m1_color), 64'(32'h55667788));
        chk("bp_q_m0_valid", 64'(m0_valid), 64'(0));
        tick();
        mid();
        chk("bp_last_m0_valid", 64'(m0_valid), 64'(1));
        chk("bp_last_m0_user",  64'(m0_user),  64'(16'h0C02));
        tick();
        mid();
        chk("bp_drain_m0_valid", 64'(m0_valid), 64'(0));
        chk("bp_drain_m1_valid", 64'(m1_valid), 64'(0));
        tick();

        // single contender on port 1 with rr=0, then port 0 joins
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idle();
            if (i < 6) set1(1'b1, 32'hFFFFFFFF, 32'h0A0B0C0D, 32'h0, 32'h0,
                            (i < 4) ? 16'hE000 + 16'(i) : 16'hE004);
            if (i == 4) set0(1'b1, 32'hFFFFFFFF, 32'h01020304, 32'h0, 32'h0, 16'hF000);
            mid();
            if (i < 6) begin
                chk("sc_s0_ready", 64'(s0_ready), 64'(i == 4));
                chk("sc_s1_ready", 64'(s1_ready), 64'(i != 4));
            end
            if (i >= 2) begin
                if (i - 2 == 4) begin
                    chk("sc_m0_valid", 64'(m0_valid), 64'(1));
                    chk("sc_m0_user",  64'(m0_user),  64'(16'hF000));
                    chk("sc_m0_color", 64'(m0_color), 64'(32'h01020304));
                end else begin
                    chk("sc_m1_valid", 64'(m1_valid), 64'(1));
                    chk("sc_m1_user",  64'(m1_user),
                        64'((i - 2 < 4) ? 16'hE000 + 16'(i - 2) : 16'hE004));
                end
            end
            tick();
        end

        // reset with two requests in flight and rr pointing at port 1
        set1(1'b1, 32'hFFFFFFFF, 32'h22222222, 32'h0, 32'h0, 16'h5101);
        mid();
        chk("rmf_s1_ready", 64'(s1_ready), 64'(1));
        tick();
        idle();
        set0(1'b1, 32'hFFFFFFFF, 32'h33333333, 32'h0, 32'h0, 16'h5001);
        mid();
        chk("rmf_s0_ready", 64'(s0_ready), 64'(1));
        tick();
        idle();
        m1_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m1_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("rmf_m0_valid", 64'(m0_valid), 64'(0));
            chk("rmf_m1_valid", 64'(m1_valid), 64'(0));
            tick();
        end
        set0(1'b1, 32'hFFFFFFFF, 32'h44444444, 32'h0, 32'h0, 16'h6000);
        set1(1'b1, 32'hFFFFFFFF, 32'h55555555, 32'h0, 32'h0, 16'h6100);
        mid();
        chk("rmf_first_s0_ready", 64'(s0_ready), 64'(1));
        chk("rmf_first_s1_ready", 64'(s1_ready), 64'(0));
        tick();
        idle();
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
